// File: rtl/qlen_expand.sv
// qlen_expand: turns a stream of length words into a stream of per-item
// indices. Each din word of length N yields N items (N+1 when INCLUSIVE),
// with a new innermost eot bit marking the final item. Outer eot bits of
// din are copied onto every item of the expansion.
//
// Handshake semantics (both ports): a transfer happens on a rising clk edge
// where valid && ready; once valid is raised the data is held stable until
// that transfer. din is consumed only together with its last dout item, or
// on its own in a single cycle when the word expands to zero items.
module qlen_expand #(
  parameter int W_LEN     = 16,
  parameter int DIN_LVL   = 1,
  parameter int INCLUSIVE = 0,
  parameter int DOWN      = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       din_valid,
  output logic                       din_ready,
  input  logic [DIN_LVL+W_LEN-1:0]   din_data,
  output logic                       dout_valid,
  input  logic                       dout_ready,
  output logic [DIN_LVL+W_LEN:0]     dout_data
);

  localparam int WT = W_LEN + 1;

  logic [W_LEN-1:0] cnt_q;
  logic [W_LEN-1:0] cnt_d;
  logic [W_LEN-1:0] cnt_cur;
  logic [W_LEN-1:0] idx_down;
  logic [WT-1:0]    total;
  logic [WT-1:0]    total_m1;
  logic             last;
  logic             xfer;

  // Item presentation: index, inner last and handshakes are all combinational
  // from din and the item counter. While rst is high the counter is treated
  // as 0 so the outputs already show the restart of the expansion.
  always_comb begin
    total      = {1'b0, din_data[W_LEN-1:0]} + WT'(INCLUSIVE != 0);
    total_m1   = total - WT'(1);
    cnt_cur    = rst ? '0 : cnt_q;
    last       = ({1'b0, cnt_cur} == total_m1);
    idx_down   = total_m1[W_LEN-1:0] - cnt_cur;
    dout_valid = din_valid && (total != '0);
    xfer       = dout_valid && dout_ready;
    din_ready  = (xfer && last) || (din_valid && (total == '0));
    dout_data  = {din_data[W_LEN +: DIN_LVL], last,
                  (DOWN != 0) ? idx_down : cnt_cur};
  end

  // Counter next state: restart on reset or after the last item, advance on
  // every other accepted item, hold while stalled.
  always_comb begin
    cnt_d = cnt_q;
    if (rst) begin
      cnt_d = '0;
    end else if (xfer && last) begin
      cnt_d = '0;
    end else if (xfer) begin
      cnt_d = cnt_q + W_LEN'(1);
    end
  end

  // Item counter register.
  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

endmodule

// File: tb/tb_qlen_expand.sv
// Bench for qlen_expand. Two instances with W_LEN=4:
//   u_a: DIN_LVL=1, INCLUSIVE=0, DOWN=0
//   u_b: DIN_LVL=2, INCLUSIVE=1, DOWN=1
// A queue-based model expands each presented din word into its list of
// expected items and is checked against the DUT on every negedge; directed
// sequences additionally check the accepted item logs against literals.
module tb_qlen_expand;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic       a_din_valid, a_din_ready, a_dout_valid, a_dout_ready;
  logic [4:0] a_din_data;
  logic [5:0] a_dout_data;
  logic       b_din_valid, b_din_ready, b_dout_valid, b_dout_ready;
  logic [5:0] b_din_data;
  logic [6:0] b_dout_data;

  qlen_expand #(.W_LEN(4), .DIN_LVL(1), .INCLUSIVE(0), .DOWN(0)) u_a (
    .clk(clk), .rst(rst),
    .din_valid(a_din_valid), .din_ready(a_din_ready), .din_data(a_din_data),
    .dout_valid(a_dout_valid), .dout_ready(a_dout_ready), .dout_data(a_dout_data)
  );

  qlen_expand #(.W_LEN(4), .DIN_LVL(2), .INCLUSIVE(1), .DOWN(1)) u_b (
    .clk(clk), .rst(rst),
    .din_valid(b_din_valid), .din_ready(b_din_ready), .din_data(b_din_data),
    .dout_valid(b_dout_valid), .dout_ready(b_dout_ready), .dout_data(b_dout_data)
  );

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [5:0] exp_qa[$];
  logic [6:0] exp_qb[$];
  logic [5:0] a_log[$];
  logic [6:0] b_log[$];
  logic [5:0] exp_a[$];
  logic [6:0] exp_b[$];
  logic       a_pat[$];
  logic       b_pat[$];
  logic       rand_rdy;
  logic       a_force0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expand the word currently on a's din into its expected item list.
  task automatic build_a();
    int total;
    logic [5:0] item;
    total = int'(a_din_data[3:0]);
    for (int p = 0; p < total; p++) begin
      item = {a_din_data[4], (p == total - 1), p[3:0]};
      exp_qa.push_back(item);
    end
  endtask

  // Expand the word on b's din: N+1 items counting down to 0.
  task automatic build_b();
    int total;
    int idx;
    logic [6:0] item;
    total = int'(b_din_data[3:0]) + 1;
    for (int p = 0; p < total; p++) begin
      idx  = total - 1 - p;
      item = {b_din_data[5:4], (p == total - 1), idx[3:0]};
      exp_qb.push_back(item);
    end
  endtask

  // ---------------- compare process ----------------
  // Checks both instances each cycle; inputs are stable from posedge+#1 to
  // the next posedge, so negedge sees exactly what the next edge will use.
  always @(negedge clk) begin
    // instance a
    if (rst) exp_qa.delete();
    if (a_din_valid && exp_qa.size() == 0) build_a();
    if (!a_din_valid) begin
      cmp("a_idle_valid", {31'b0, a_dout_valid}, 32'd0);
      cmp("a_idle_ready", {31'b0, a_din_ready}, 32'd0);
    end else if (exp_qa.size() == 0) begin
      cmp("a_zero_valid", {31'b0, a_dout_valid}, 32'd0);
      cmp("a_zero_ready", {31'b0, a_din_ready}, 32'd1);
    end else begin
      cmp("a_valid", {31'b0, a_dout_valid}, 32'd1);
      cmp("a_data", {26'b0, a_dout_data}, {26'b0, exp_qa[0]});
      cmp("a_din_ready", {31'b0, a_din_ready},
          {31'b0, (a_dout_ready && exp_qa.size() == 1)});
      if (a_dout_ready) begin
        a_log.push_back(a_dout_data);
        void'(exp_qa.pop_front());
      end
    end
    if (rst) exp_qa.delete();

    // instance b
    if (rst) exp_qb.delete();
    if (b_din_valid && exp_qb.size() == 0) build_b();
    if (!b_din_valid) begin
      cmp("b_idle_valid", {31'b0, b_dout_valid}, 32'd0);
      cmp("b_idle_ready", {31'b0, b_din_ready}, 32'd0);
    end else begin
      cmp("b_valid", {31'b0, b_dout_valid}, 32'd1);
      cmp("b_data", {25'b0, b_dout_data}, {25'b0, exp_qb[0]});
      cmp("b_din_ready", {31'b0, b_din_ready},
          {31'b0, (b_dout_ready && exp_qb.size() == 1)});
      if (b_dout_ready) begin
        b_log.push_back(b_dout_data);
        void'(exp_qb.pop_front());
      end
    end
    if (rst) exp_qb.delete();
  end

  // ---------------- dout_ready drivers ----------------
  always @(posedge clk) begin
    #2;
    if (a_force0) a_dout_ready = 1'b0;
    else if (a_pat.size() != 0) a_dout_ready = a_pat.pop_front();
    else if (rand_rdy) a_dout_ready = 1'($urandom_range(0, 1));
    else a_dout_ready = 1'b1;
    if (b_pat.size() != 0) b_dout_ready = b_pat.pop_front();
    else if (rand_rdy) b_dout_ready = 1'($urandom_range(0, 1));
    else b_dout_ready = 1'b1;
  end

  // ---------------- din driver tasks ----------------
  task automatic a_send(input logic eot, input logic [3:0] len);
    int n;
    n = 0;
    a_din_valid = 1'b1;
    a_din_data  = {eot, len};
    do begin
      @(negedge clk);
      n++;
    end while (!a_din_ready && n < 300);
    cmp("a_send_accepted", {31'b0, a_din_ready}, 32'd1);
    @(posedge clk);
    #1;
    a_din_valid = 1'b0;
  endtask

  task automatic b_send(input logic [1:0] eot, input logic [3:0] len);
    int n;
    n = 0;
    b_din_valid = 1'b1;
    b_din_data  = {eot, len};
    do begin
      @(negedge clk);
      n++;
    end while (!b_din_ready && n < 300);
    cmp("b_send_accepted", {31'b0, b_din_ready}, 32'd1);
    @(posedge clk);
    #1;
    b_din_valid = 1'b0;
  endtask

  task automatic chk_a(input string name);
    cmp({name, "_count"}, a_log.size(), exp_a.size());
    for (int i = 0; i < exp_a.size() && i < a_log.size(); i++)
      cmp(name, {26'b0, a_log[i]}, {26'b0, exp_a[i]});
    a_log.delete();
  endtask

  task automatic chk_b(input string name);
    cmp({name, "_count"}, b_log.size(), exp_b.size());
    for (int i = 0; i < exp_b.size() && i < b_log.size(); i++)
      cmp(name, {25'b0, b_log[i]}, {25'b0, exp_b[i]});
    b_log.delete();
  endtask

  function automatic logic [3:0] rand_len();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return 4'd0;
    if (r == 1) return 4'd15;
    return 4'($urandom_range(1, 6));
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    int n;
    logic [31:0] r;
    rst = 1'b1;
    a_din_valid = 1'b0; a_din_data = '0; a_dout_ready = 1'b1;
    b_din_valid = 1'b0; b_din_data = '0; b_dout_ready = 1'b1;
    rand_rdy = 1'b0; a_force0 = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    a_log.delete(); b_log.delete();

    // len=3 counting up
    a_send(1'b0, 4'd3);
    exp_a = '{6'h00, 6'h01, 6'h12};
    chk_a("a_len3");

    // zero-length word dropped, next word expands
    a_send(1'b1, 4'd0);
    a_send(1'b0, 4'd2);
    exp_a = '{6'h00, 6'h11};
    chk_a("a_len0_then2");

    // backpressure pattern
    a_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    a_send(1'b0, 4'd4);
    exp_a = '{6'h00, 6'h01, 6'h02, 6'h13};
    chk_a("a_stall");

    // outer eot pass-through
    a_send(1'b0, 4'd2);
    a_send(1'b1, 4'd2);
    exp_a = '{6'h00, 6'h11, 6'h20, 6'h31};
    chk_a("a_outer_eot");

    // reset in the middle of an expansion
    fork
      a_send(1'b0, 4'd5);
      begin
        n = 0;
        do begin
          @(negedge clk); #1;
          n++;
        end while (a_log.size() < 3 && n < 300);
        @(posedge clk); #1;
        rst = 1'b1; a_force0 = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; a_force0 = 1'b0;
      end
    join
    exp_a = '{6'h00, 6'h01, 6'h02, 6'h00, 6'h01, 6'h02, 6'h03, 6'h14};
    chk_a("a_mid_reset");

    // inclusive, counting down
    b_log.delete();
    b_send(2'b00, 4'd3);
    exp_b = '{7'h03, 7'h02, 7'h01, 7'h10};
    chk_b("b_len3_incl_down");

    b_send(2'b10, 4'd1);
    exp_b = '{7'h41, 7'h50};
    chk_b("b_outer_eot");

    b_send(2'b01, 4'd0);
    exp_b = '{7'h30};
    chk_b("b_len0_incl");

    b_send(2'b00, 4'd15);
    exp_b = '{7'h0F, 7'h0E, 7'h0D, 7'h0C, 7'h0B, 7'h0A, 7'h09, 7'h08,
              7'h07, 7'h06, 7'h05, 7'h04, 7'h03, 7'h02, 7'h01, 7'h10};
    chk_b("b_max_len");

    // randomized traffic with random backpressure
    rand_rdy = 1'b1;
    fork
      for (int i = 0; i < 150; i++) begin
        r = $urandom;
        repeat (r[9:8] == 2'b00 ? 1 : 0) begin @(posedge clk); #1; end
        a_send(r[4], rand_len());
      end
      for (int i = 0; i < 150; i++) begin
        logic [31:0] rb;
        rb = $urandom;
        repeat (rb[9:8] == 2'b00 ? 1 : 0) begin @(posedge clk); #1; end
        b_send(rb[5:4], rand_len());
      end
    join
    rand_rdy = 1'b0;
    repeat (3) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
